// File: rtl/mul_exec_unit.sv
// Multiply execution unit: accepts one issued MUL-class op per cycle and broadcasts
// dst tag + result on the wake bus LATENCY cycles later. `MUL_WORD_OPS_EN builds MULW.
module mul_exec_unit #(
    parameter int XLEN    = 64,
    parameter int TAG_W   = 6,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op,
    input  logic [XLEN-1:0]  issue_src1,
    input  logic [XLEN-1:0]  issue_src2,
    input  logic [TAG_W-1:0] issue_dst,
    output logic             issue_ready,
    input  logic             stall,
    input  logic             flush,
    output logic             wake_valid,
    output logic [TAG_W-1:0] wake_dst,
    output logic [XLEN-1:0]  wake_data,
    output logic             busy
);

    localparam int EW = XLEN + 1;
    localparam int NS = (LATENCY > 1) ? LATENCY - 1 : 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    // Handshake: an issue transfers on a cycle with issue_valid && issue_ready;
    // a wake is consumed on a cycle with wake_valid && !stall. flush beats stall.
    logic accept;
    assign issue_ready = !stall && !reset;
    assign accept      = issue_valid && issue_ready;

    logic            sign_a, sign_b;
    logic [EW-1:0]   ext_a, ext_b;

    always_comb begin
        sign_a = (issue_op == OP_MUL) || (issue_op == OP_MULH) || (issue_op == OP_MULHSU);
        sign_b = (issue_op == OP_MUL) || (issue_op == OP_MULH);
        ext_a  = {sign_a & issue_src1[XLEN-1], issue_src1};
        ext_b  = {sign_b & issue_src2[XLEN-1], issue_src2};
    end

    logic [NS-1:0]    st_valid;
    logic [2:0]       st_op  [NS];
    logic [TAG_W-1:0] st_dst [NS];
    logic [EW-1:0]    st_a   [NS];
    logic [EW-1:0]    st_b   [NS];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            st_valid <= '0;
        end else if (!stall) begin
            st_valid[0] <= accept;
            for (int i = 1; i < NS; i++) st_valid[i] <= st_valid[i-1];
        end
    end

    // Payload needs no reset: it is only observed behind its valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            st_op[0]  <= issue_op;
            st_dst[0] <= issue_dst;
            st_a[0]   <= ext_a;
            st_b[0]   <= ext_b;
            for (int i = 1; i < NS; i++) begin
                st_op[i]  <= st_op[i-1];
                st_dst[i] <= st_dst[i-1];
                st_a[i]   <= st_a[i-1];
                st_b[i]   <= st_b[i-1];
            end
        end
    end

    logic             feed_valid;
    logic [2:0]       feed_op;
    logic [TAG_W-1:0] feed_dst;
    logic [EW-1:0]    feed_a, feed_b;

    generate
        if (LATENCY == 1) begin : g_direct
            assign feed_valid = accept;
            assign feed_op    = issue_op;
            assign feed_dst   = issue_dst;
            assign feed_a     = ext_a;
            assign feed_b     = ext_b;
            assign busy       = wake_valid;
        end else begin : g_staged
            assign feed_valid = st_valid[NS-1];
            assign feed_op    = st_op[NS-1];
            assign feed_dst   = st_dst[NS-1];
            assign feed_a     = st_a[NS-1];
            assign feed_b     = st_b[NS-1];
            assign busy       = wake_valid | (|st_valid);
        end
    endgenerate

    // Only the low 2*XLEN bits of the 130-bit product are ever selected.
    logic [2*XLEN-1:0] wide_a, wide_b, prod;
    logic [XLEN-1:0]   result;
`ifdef MUL_WORD_OPS_EN
    logic [31:0]       word_prod;
`endif

    always_comb begin
        wide_a = {{(XLEN-1){feed_a[EW-1]}}, feed_a};
        wide_b = {{(XLEN-1){feed_b[EW-1]}}, feed_b};
        prod   = wide_a * wide_b;
`ifdef MUL_WORD_OPS_EN
        word_prod = feed_a[31:0] * feed_b[31:0];
`endif
        case (feed_op)
            OP_MUL:                        result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
`ifdef MUL_WORD_OPS_EN
            OP_MULW:                       result = {{(XLEN-32){word_prod[31]}}, word_prod};
`endif
            default:                       result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wake_valid <= 1'b0;
            wake_dst   <= '0;
            wake_data  <= '0;
        end else if (flush) begin
            wake_valid <= 1'b0;
        end else if (!stall) begin
            wake_valid <= feed_valid;
            if (feed_valid) begin
                wake_dst  <= feed_dst;
                wake_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_mul_exec_unit.sv
// Directed testbench for mul_exec_unit (LATENCY=3); MULW expectation follows `MUL_WORD_OPS_EN.
module tb_mul_exec_unit;

    localparam int XLEN  = 64;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             issue_valid = 1'b0;
    logic [2:0]       issue_op = 3'd0;
    logic [XLEN-1:0]  issue_src1 = '0;
    logic [XLEN-1:0]  issue_src2 = '0;
    logic [TAG_W-1:0] issue_dst = '0;
    logic             issue_ready;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             wake_valid;
    logic [TAG_W-1:0] wake_dst;
    logic [XLEN-1:0]  wake_data;
    logic             busy;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0]  exp_q[$];
    logic [TAG_W-1:0] exp_dst_q[$];

    mul_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(3)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_dst(issue_dst),
        .issue_ready(issue_ready), .stall(stall), .flush(flush),
        .wake_valid(wake_valid), .wake_dst(wake_dst), .wake_data(wake_data),
        .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver
    task automatic drive_issue(input logic [2:0] op, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [TAG_W-1:0] dst);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_src1  = a;
        issue_src2  = b;
        issue_dst   = dst;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", issue_ready); end
        total++; if (wake_valid !== 1'b0) begin bad++; $display("FAIL reset_wake_valid got=%0b exp=0", wake_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (wake_dst !== '0) begin bad++; $display("FAIL reset_wake_dst got=%0d exp=0", wake_dst); end
        total++; if (wake_data !== '0) begin bad++; $display("FAIL reset_wake_data got=%h exp=0", wake_data); end
        reset = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", issue_ready); end
    endtask

    // Single op: wake must appear exactly 3 cycles after acceptance, one cycle wide.
    task automatic test_single(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [TAG_W-1:0] dst,
                               input logic [XLEN-1:0] exp_data);
        drive_issue(op, a, b, dst);
        tick();
        issue_valid = 1'b0;
        total++; if (wake_valid !== 1'b0) begin bad++; $display("FAIL %s_early1 wake_valid got=%0b exp=0", name, wake_valid); end
        tick();
        total++; if (wake_valid !== 1'b0) begin bad++; $display("FAIL %s_early2 wake_valid got=%0b exp=0", name, wake_valid); end
        tick();
        total++; if (wake_valid !== 1'b1) begin bad++; $display("FAIL %s_wake_valid got=%0b exp=1", name, wake_valid); end
        total++; if (wake_dst !== dst) begin bad++; $display("FAIL %s_dst got=%0d exp=%0d", name, wake_dst, dst); end
        total++; if (wake_data !== exp_data) begin bad++; $display("FAIL %s_data got=%h exp=%h", name, wake_data, exp_data); end
        tick();
        total++; if (wake_valid !== 1'b0) begin bad++; $display("FAIL %s_one_shot wake_valid got=%0b exp=0", name, wake_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle busy got=%0b exp=0", name, busy); end
    endtask

    task automatic test_arith();
        test_single("mul", 3'd0, -64'sd3, 64'd5, 6'd7, 64'hFFFF_FFFF_FFFF_FFF1);
        test_single("mulh", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd9,
                    64'h4000_0000_0000_0000);
        test_single("mulhu", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd10, 64'd1);
        test_single("mulhsu", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd11, 64'hFFFF_FFFF_FFFF_FFFF);
        test_single("mulh_neg", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd12, 64'hFFFF_FFFF_FFFF_FFFF);
        test_single("mulhu_hi", 3'd3, 64'h8000_0000_0000_0000, 64'd4, 6'd13, 64'd2);
        test_single("reserved", 3'd6, 64'd123, 64'd456, 6'd14, 64'd0);
    endtask

    task automatic test_mulw();
`ifdef MUL_WORD_OPS_EN
        test_single("mulw", 3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'd15, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        test_single("mulw_off", 3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'd15, 64'd0);
`endif
    endtask

    // Four back-to-back MULs (src1=k, src2=10, dst=k); optional 2-cycle stall at stall_at.
    task automatic run_stream(input string name, input int stall_at);
        int issued = 0;
        int held   = 0;
        int last_wake;
        logic exp_wv;
        logic [XLEN-1:0]  ed;
        logic [TAG_W-1:0] et;
        last_wake = (stall_at >= 0) ? 8 : 6;
        for (int cyc = 0; cyc < 12; cyc++) begin
            stall = (stall_at >= 0) && (cyc == stall_at || cyc == stall_at + 1);
            if (issued < 4 && !stall) begin
                drive_issue(3'd0, XLEN'(issued + 1), 64'd10, TAG_W'(issued + 1));
            end else begin
                issue_valid = 1'b0;
            end
            #1;
            exp_wv = (cyc >= 3) && (cyc <= last_wake);
            total++; if (wake_valid !== exp_wv) begin bad++; $display("FAIL %s_wv_c%0d got=%0b exp=%0b", name, cyc, wake_valid, exp_wv); end
            if (wake_valid && stall) begin
                held++;
                total++; if (wake_dst !== 6'd3) begin bad++; $display("FAIL %s_held_dst got=%0d exp=3", name, wake_dst); end
            end
            if (wake_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    bad++; total++; $display("FAIL %s_extra_wake got dst=%0d exp=none", name, wake_dst);
                end else begin
                    ed = exp_q.pop_front();
                    et = exp_dst_q.pop_front();
                    total++; if (wake_dst !== et) begin bad++; $display("FAIL %s_dst got=%0d exp=%0d", name, wake_dst, et); end
                    total++; if (wake_data !== ed) begin bad++; $display("FAIL %s_data got=%h exp=%h", name, wake_data, ed); end
                end
            end
            if (issue_valid && issue_ready) begin
                exp_q.push_back(64'(10 * (issued + 1)));
                exp_dst_q.push_back(TAG_W'(issued + 1));
                issued++;
            end
            tick();
        end
        stall = 1'b0;
        issue_valid = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL %s_lost got=%0d exp=0 pending", name, exp_q.size()); end
        total++; if (held != ((stall_at >= 0) ? 2 : 0)) begin bad++; $display("FAIL %s_held got=%0d exp=%0d", name, held, (stall_at >= 0) ? 2 : 0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end got=%0b exp=0", name, busy); end
        exp_q.delete();
        exp_dst_q.delete();
    endtask

    task automatic test_back_to_back();
        run_stream("b2b", -1);
    endtask

    task automatic test_stall();
        run_stream("stall", 5);
    endtask

    task automatic test_flush();
        drive_issue(3'd0, 64'd2, 64'd3, 6'd20);
        tick();
        drive_issue(3'd0, 64'd4, 64'd5, 6'd21);
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%0b exp=1", busy); end
        drive_issue(3'd0, 64'd6, 64'd7, 6'd22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%0b exp=0", busy); end
        for (int i = 0; i < 5; i++) begin
            total++; if (wake_valid !== 1'b0) begin bad++; $display("FAIL flush_wake_c%0d got=%0b exp=0", i, wake_valid); end
            tick();
        end
        // flush must win over a simultaneous stall
        drive_issue(3'd0, 64'd1, 64'd1, 6'd23);
        tick();
        issue_valid = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_over_stall busy got=%0b exp=0", busy); end
        tick();
        tick();
        tick();
        total++; if (wake_valid !== 1'b0) begin bad++; $display("FAIL flush_over_stall wake got=%0b exp=0", wake_valid); end
    endtask

    // report
    initial begin
        test_reset();
        test_arith();
        test_mulw();
        test_back_to_back();
        test_stall();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
